// File: rtl/if_stage_if.sv
// if_stage_if: bundle between the instruction-fetch stage, the next-PC
// calculator/hazard unit, the instruction memory and the decode stage.
//   next_PC, stall, flush : control into the fetch stage
//   im_addr / im_rdata    : instruction-memory word index and read data
//   PC_F, PC4_F           : current fetch PC and PC+4
//   instr_D, PC_D, PC4_D, PC8_D, valid_D, adel_D : IF/ID register contents
// master = surrounding pipeline / memory, slave = if_stage.
interface if_stage_if #(
  parameter int AW = 12
);
  logic [31:0]   next_PC;
  logic          stall;
  logic          flush;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_rdata;
  logic [31:0]   PC_F;
  logic [31:0]   PC4_F;
  logic [31:0]   instr_D;
  logic [31:0]   PC_D;
  logic [31:0]   PC4_D;
  logic [31:0]   PC8_D;
  logic          valid_D;
  logic          adel_D;

  modport master (
    output next_PC, stall, flush, im_rdata,
    input  im_addr, PC_F, PC4_F, instr_D, PC_D, PC4_D, PC8_D, valid_D, adel_D
  );

  modport slave (
    input  next_PC, stall, flush, im_rdata,
    output im_addr, PC_F, PC4_F, instr_D, PC_D, PC4_D, PC8_D, valid_D, adel_D
  );
endinterface

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the five-stage MIPS pipeline.
// Holds the PC register and the IF/ID pipeline register, drives the
// instruction-memory word index, flags illegal fetch addresses and hands
// the fetched instruction with PC, PC+4, PC+8 to decode.
// Ports:
//   clk   : pipeline clock, rising-edge
//   reset : asynchronous, active-low reset
//   bus   : if_stage_if slave modport (control, memory port, IF/ID outputs)
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input logic        clk,
  input logic        reset,
  if_stage_if.slave  bus
);

  localparam int unsigned AW = $clog2(IM_WORDS);

  // 33-bit bounds so that IM_BASE + 4*IM_WORDS cannot wrap to zero.
  localparam logic [32:0] IM_LO = {1'b0, IM_BASE};
  localparam logic [32:0] IM_HI = IM_LO + (33'(IM_WORDS) << 2);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pc4d_q, pc4d_d;
  logic [31:0] pc8d_q, pc8d_d;
  logic        valid_q, valid_d;
  logic        adel_q, adel_d;

  logic [32:0] pc_ext_s;
  logic        illegal_s;
  logic [31:0] fetch_word_s;

  assign pc_ext_s  = {1'b0, pc_q};
  assign illegal_s = (pc_q[1:0] != 2'b00) || (pc_ext_s < IM_LO) || (pc_ext_s >= IM_HI);

  // The index is driven even for illegal PCs; that data is simply discarded.
  assign bus.im_addr = AW'((pc_q - IM_BASE) >> 2);

  // Illegal fetches become a NOP (sll $0,$0,0).
  assign fetch_word_s = illegal_s ? 32'h0000_0000 : bus.im_rdata;

  assign bus.PC_F    = pc_q;
  assign bus.PC4_F   = pc_q + 32'd4;
  assign bus.instr_D = instr_q;
  assign bus.PC_D    = pcd_q;
  assign bus.PC4_D   = pc4d_q;
  assign bus.PC8_D   = pc8d_q;
  assign bus.valid_D = valid_q;
  assign bus.adel_D  = adel_q;

  // PC next-state: hold on stall, otherwise take the calculator's next_PC.
  always_comb begin
    pc_d = pc_q;
    if (bus.stall) begin
      pc_d = pc_q;
    end else begin
      pc_d = bus.next_PC;
    end
  end

  // IF/ID next-state: stall beats flush so a delay-slot instruction survives.
  always_comb begin
    instr_d = instr_q;
    pcd_d   = pcd_q;
    pc4d_d  = pc4d_q;
    pc8d_d  = pc8d_q;
    valid_d = valid_q;
    adel_d  = adel_q;
    if (bus.stall) begin
      instr_d = instr_q;
    end else if (bus.flush) begin
      instr_d = 32'h0000_0000;
      pcd_d   = pc_q;
      pc4d_d  = pc_q + 32'd4;
      pc8d_d  = pc_q + 32'd8;
      valid_d = 1'b0;
      adel_d  = 1'b0;
    end else begin
      instr_d = fetch_word_s;
      pcd_d   = pc_q;
      pc4d_d  = pc_q + 32'd4;
      pc8d_d  = pc_q + 32'd8;
      valid_d = 1'b1;
      adel_d  = illegal_s;
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q <= 32'h0000_0000;
      pcd_q   <= RESET_PC;
      pc4d_q  <= RESET_PC + 32'd4;
      pc8d_q  <= RESET_PC + 32'd8;
      valid_q <= 1'b0;
      adel_q  <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pcd_q   <= pcd_d;
      pc4d_q  <= pc4d_d;
      pc8d_q  <= pc8d_d;
      valid_q <= valid_d;
      adel_q  <= adel_d;
    end
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline. Holds the architectural PC register and the IF/ID pipeline register. Loads the next-PC value produced combinationally by the next-PC calculator every cycle unless stalled. Drives the instruction-memory read port, detects illegal fetch addresses, and presents the fetched instruction plus its PC, PC+4 and PC+8 to the decode stage.

## Interface
- RESET_PC, 32'h0000_3000, PC value after reset
- IM_BASE, 32'h0000_3000, byte address of instruction-memory word 0
- IM_WORDS, 4096, instruction-memory depth in 32-bit words (power of two)
- clk  input  1  pipeline clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low; asserted (0) forces all state to reset values immediately
- next_PC  input  32  next fetch address from the next-PC calculator
- stall  input  1  hazard-unit stall; holds PC and IF/ID
- flush  input  1  clears IF/ID to a bubble on the next edge
- im_addr  output  log2(IM_WORDS)  instruction-memory word index
- im_rdata  input  32  combinational instruction-memory read data for im_addr
- PC_F  output  32  current fetch PC (register)
- PC4_F  output  32  PC_F + 4, fed back to the next-PC calculator
- instr_D  output  32  instruction in decode
- PC_D, PC4_D, PC8_D  output  32 each  decode-stage PC, PC+4, PC+8 (link value)
- valid_D  output  1  IF/ID holds a real instruction (0 = bubble)
- adel_D  output  1  decode-stage instruction came from an illegal fetch address

## Operation
- Fetch legality (combinational on PC_F): illegal if PC_F[1:0] != 0, PC_F < IM_BASE, or PC_F >= IM_BASE + 4*IM_WORDS. Compare with 33-bit arithmetic so the upper bound does not wrap.
- im_addr = (PC_F - IM_BASE)[log2(IM_WORDS)+1:2]. It is driven even when the fetch is illegal, but its data is discarded.
- Fetched word = im_rdata if legal, else 32'h0000_0000 (sll $0,$0,0 = NOP).
- PC4_F = PC_F + 4, modulo 2^32.
- PC register, per rising edge, in priority order:
  - reset=0: RESET_PC.
  - stall=1: hold.
  - otherwise: next_PC.
- IF/ID register, per rising edge, in priority order:
  - reset=0: instr_D=0, PC_D=RESET_PC, PC4_D=RESET_PC+4, PC8_D=RESET_PC+8, valid_D=0, adel_D=0.
  - stall=1: hold all fields. A flush arriving in the same cycle is ignored; stall wins so a branch delay-slot instruction is never lost.
  - flush=1: instr_D=0, valid_D=0, adel_D=0. PC_D/PC4_D/PC8_D still load PC_F, PC_F+4, PC_F+8.
  - otherwise: instr_D = fetched word, PC_D=PC_F, PC4_D=PC_F+4, PC8_D=PC_F+8, valid_D=1, adel_D = illegal.
- next_PC is not checked here. An illegal next_PC loads normally and is flagged when it is fetched.
- No internal state other than the two registers; the block has no FSM beyond pipeline hold/advance.

## Timing
- Reset values while reset=0:
  - PC_F=RESET_PC, PC4_F=RESET_PC+4, im_addr=(RESET_PC-IM_BASE)>>2.
  - IF/ID outputs as listed above.
- First fetch at RESET_PC occurs in the first cycle after reset deasserts. Deassertion is assumed synchronous to clk at system level.
- Latency:
  - next_PC → PC_F: 1 edge.
  - PC_F → instr_D/PC_D: 1 edge. Instruction memory is read in the same cycle, with no wait states.
- Delay slot: the instruction at the branch PC+4 is fetched in the cycle the branch is in decode. It reaches decode normally; this block does not squash it.
- Stall of N cycles: PC_F and all IF/ID outputs remain bit-identical for N edges, then advance on the first edge with stall=0.
- Reset mid-operation: asynchronous clear, no dependence on clk. Pending stall/flush has no effect after release.
- PC wrap: PC_F=32'hFFFF_FFFC gives PC4_F=0. That fetch is flagged illegal (out of range).

## Test plan
- Reset then free-run, next_PC driven with PC4_F:
  - reset=0 gives PC_F=0x3000, valid_D=0.
  - After release, PC_F steps 0x3004, 0x3008.
  - instr_D equals memory word 0 one edge after PC_F=0x3000; PC8_D=0x3008.
- Stall 3 cycles with PC_F=0x3010:
  - PC_F stays 0x3010 and instr_D/PC_D stay 0x300C's contents for 3 edges.
  - Fourth edge advances to PC_F=next_PC.
- Flush with stall=0 at PC_F=0x3020: next edge valid_D=0, instr_D=0, PC_D=0x3020. Flush with stall=1: IF/ID unchanged.
- Illegal fetch, next_PC set to each of:
  - 0x3002 (misaligned): next cycle instr_D=0, adel_D=1, valid_D=1, PC_D=0x3002.
  - 0x2FFC (below base): same response.
  - 0x7000 with IM_WORDS=4096 (above range): same response.
- Boundary fetch at 0x6FFC (last word, IM_WORDS=4096): adel_D=0, im_addr=4095.
- Asynchronous reset pulse mid-stream between clock edges: outputs return to reset values immediately, before the next rising edge.
